// File: rtl/data_register_file.sv
// Two-read/one-write register file that self-clears every entry after reset
// (one per cycle) before accepting requests; reads are registered, writes bypass.
module data_register_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              rd_valid,
  output logic              ready,
  output logic              wr_err
);

  typedef enum logic {S_INIT, S_READY} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] init_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_accept, wr_reject, rd_accept;
  logic [DATA_W-1:0] rd_val_a, rd_val_b;

  // Out-of-range addresses read as zero; a same-cycle accepted write wins over memory.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if ({1'b0, addr} >= DEPTH_L)           return '0;
    else if (wr_accept && wr_addr == addr) return wr_data;
    else                                   return mem[addr];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    ready      = 1'b0;
    wr_accept  = 1'b0;
    wr_reject  = 1'b0;
    rd_accept  = 1'b0;
    case (state)
      S_INIT: begin
        wr_reject = we;
        if (init_cnt == LAST_IDX) state_next = S_READY;
      end
      S_READY: begin
        ready     = 1'b1;
        wr_accept = we && ({1'b0, wr_addr} < DEPTH_L);
        wr_reject = we && !({1'b0, wr_addr} < DEPTH_L);
        rd_accept = rd_en;
      end
      default: state_next = S_INIT;
    endcase
  end

  always_comb begin
    rd_val_a = read_port(address_a);
    rd_val_b = read_port(address_b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_cnt <= '0;
      a        <= '0;
      b        <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
      wr_err   <= wr_reject;
      rd_valid <= rd_accept;
      if (rd_accept) begin
        a <= rd_val_a;
        b <= rd_val_b;
      end
    end
  end

  // NOTE: the array has no reset term; the INIT sweep clears it one entry per
  // cycle, which keeps it mappable to plain RAM/flop arrays without reset.
  always_ff @(posedge clk) begin
    if (state == S_INIT) mem[init_cnt] <= '0;
    else if (wr_accept)  mem[wr_addr]  <= wr_data;
  end

endmodule

// File: tb/tb_data_register_file.sv
// Directed bench for data_register_file: a DEPTH=16 and a DEPTH=10 instance
// share stimulus; a vector table covers reads/writes/bypass, sequences cover reset/INIT.
module tb_data_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [3:0]  address_a, address_b;
  logic [15:0] a, b, a10, b10;
  logic        rd_valid, ready, wr_err;
  logic        rd_valid10, ready10, wr_err10;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_register_file #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .address_a(address_a), .address_b(address_b),
    .a(a), .b(b), .rd_valid(rd_valid), .ready(ready), .wr_err(wr_err)
  );

  data_register_file #(.DATA_W(16), .ADDR_W(4), .DEPTH(10)) dut10 (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .address_a(address_a), .address_b(address_b),
    .a(a10), .b(b10), .rd_valid(rd_valid10), .ready(ready10), .wr_err(wr_err10)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        rd;
    logic [3:0]  aa;
    logic [3:0]  ab;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ev;
    logic        ee;
    logic        ee10;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                       input logic r, input logic [3:0] aa, input logic [3:0] ab);
    we = w; wr_addr = wa; wr_data = wd; rd_en = r; address_a = aa; address_b = ab;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a"}, a, 0);
    check({tag, " b"}, b, 0);
    check({tag, " rd_valid"}, rd_valid, 0);
    check({tag, " ready"}, ready, 0);
    check({tag, " wr_err"}, wr_err, 0);
    check({tag, " ready10"}, ready10, 0);
  endtask

  logic [15:0] model10 [10];

  initial begin
    //            we wa  wd       rd aa  ab  ea       eb       ev ee ee10
    vecs[0] = '{1, 4, 16'h00FF, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0};
    vecs[1] = '{0, 0, 16'h0000, 1, 4, 0, 16'h00FF, 16'h0000, 1, 0, 0};
    vecs[2] = '{1, 7, 16'h0010, 1, 7, 4, 16'h0010, 16'h00FF, 1, 0, 0};
    vecs[3] = '{1, 12, 16'h0040, 0, 0, 0, 16'h0010, 16'h00FF, 0, 0, 1};
    vecs[4] = '{0, 0, 16'h0000, 1, 12, 12, 16'h0040, 16'h0040, 1, 0, 0};
    vecs[5] = '{1, 2, 16'h1234, 1, 2, 2, 16'h1234, 16'h1234, 1, 0, 0};
    vecs[6] = '{1, 15, 16'hFFFF, 1, 15, 7, 16'hFFFF, 16'h0010, 1, 0, 1};
    vecs[7] = '{1, 4, 16'hA5A5, 1, 3, 4, 16'h0000, 16'hA5A5, 1, 0, 0};
    vecs[8] = '{0, 0, 16'h0000, 1, 4, 2, 16'hA5A5, 16'h1234, 1, 0, 0};
    vecs[9] = '{0, 0, 16'h0000, 0, 0, 0, 16'hA5A5, 16'h1234, 0, 0, 0};
    model10 = '{16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'hA5A5,
                16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000};

    // Reset state, including across a clock edge while held.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check_all_zero("por");
    tick();
    check_all_zero("por held");
    reset = 1'b0;

    // Init length: DEPTH=10 ready after 10 edges, DEPTH=16 after 16.
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 9)  check("ready10 edge 9", ready10, 0);
      if (i == 10) check("ready10 edge 10", ready10, 1);
      if (i == 15) check("ready edge 15", ready, 0);
    end
    check("ready edge 16", ready, 1);

    // Every address reads zero after the clear sweep.
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 1, 4'(i), 4'(15 - i));
      tick();
      check($sformatf("clear a[%0d]", i), a, 0);
      check($sformatf("clear b[%0d]", 15 - i), b, 0);
      check($sformatf("clear valid %0d", i), rd_valid, 1);
      check($sformatf("clear a10[%0d]", i), a10, 0);
    end

    // Vector table: read/write, bypass, hold, range rejection on DEPTH=10.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].aa, vecs[i].ab);
      tick();
      check($sformatf("vec%0d a", i), a, vecs[i].ea);
      check($sformatf("vec%0d b", i), b, vecs[i].eb);
      check($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].ev);
      check($sformatf("vec%0d wr_err", i), wr_err, vecs[i].ee);
      check($sformatf("vec%0d wr_err10", i), wr_err10, vecs[i].ee10);
    end

    // DEPTH=10: out-of-range reads return 0, in-range entries match the model.
    drive(0, 0, 0, 1, 12, 15);
    tick();
    check("d10 read 12", a10, 0);
    check("d10 read 15", b10, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 4'(i), 4'(9 - i));
      tick();
      check($sformatf("d10 a[%0d]", i), a10, model10[i]);
      check($sformatf("d10 b[%0d]", 9 - i), b10, model10[9 - i]);
    end

    // Mid-READY reset: outputs clear immediately, full sweep reruns.
    drive(0, 0, 0, 1, 2, 4);
    tick();
    check("pre-reset a", a, 16'h1234);
    reset = 1'b1;
    #1;
    check_all_zero("mid reset");
    tick();
    reset = 1'b0;
    drive(1, 3, 16'h7777, 1, 3, 2);
    tick();
    check("init wr_err", wr_err, 1);
    check("init wr_err10", wr_err10, 1);
    check("init rd_valid", rd_valid, 0);
    check("init a hold", a, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("init wr_err end", wr_err, 0);
    for (int i = 3; i <= 15; i++) tick();
    check("re-init ready edge 15", ready, 0);
    tick();
    check("re-init ready edge 16", ready, 1);
    drive(0, 0, 0, 1, 3, 2);
    tick();
    check("post-init addr 3", a, 0);
    check("post-init addr 2", b, 0);
    check("post-init valid", rd_valid, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("idle valid drop", rd_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
